// File: rtl/arb_pkg.sv
// Shared definitions for the 3-source round-robin arbiter: FSM states,
// source indices and the owner-to-mux-select mapping.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] SRC0 = 2'd0;
  localparam logic [1:0] SRC1 = 2'd1;
  localparam logic [1:0] SRC2 = 2'd2;

  // Returns {sel1, sel0}; index 3 is treated as source 0.
  function automatic logic [1:0] owner_sel(input logic [1:0] owner);
    case (owner)
      SRC1:    owner_sel = 2'b01;
      SRC2:    owner_sel = 2'b10;
      default: owner_sel = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] idx);
    inc3 = (idx >= SRC2) ? SRC0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mux3.sv
// W-bit 3:1 data mux; sel1 has priority and selects din2 regardless of sel0.
module mux3 #(
  parameter int unsigned W = 1
) (
  input  logic         sel0,
  input  logic         sel1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic [W-1:0] y
);

  always_comb begin
    if (sel1)      y = d2;
    else if (sel0) y = d1;
    else           y = d0;
  end

endmodule

// File: rtl/rr_arb3.sv
// Three-requester round-robin arbiter with a per-owner burst budget, steering
// the registered selects of a shared 3:1 data mux.
module rr_arb3
  import arb_pkg::*;
#(
  parameter int unsigned W        = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  output logic [2:0]   gnt,
  output logic         sel0,
  output logic         sel1,
  output logic [W-1:0] dout,
  output logic         valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      SRC1:    onehot = 3'b010;
      SRC2:    onehot = 3'b100;
      default: onehot = 3'b001;
    endcase
  endfunction

  // Returns {found, index}: first set bit of r scanning from p upward mod 3.
  function automatic logic [2:0] arb_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] idx;
    arb_pick = '0;
    idx      = (p == 2'd3) ? SRC0 : p;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!arb_pick[2] && r[idx]) arb_pick = {1'b1, idx};
      idx = inc3(idx);
    end
  endfunction

  logic [1:0] own;
  logic [2:0] own_mask;
  logic       own_req, others;
  logic [2:0] pick;
  logic       take, drop;

  always_comb begin
    own      = (owner_q == 2'd3) ? SRC0 : owner_q;
    own_mask = onehot(own);
    own_req  = |(req & own_mask);
    others   = |(req & ~own_mask);
    pick     = '0;
    take     = 1'b0;
    drop     = 1'b0;

    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        pick = arb_pick(req, ptr_q);
        take = |req;
      end
      BUSY: begin
        if (!own_req || (hold_q == HOLD_LAST && others)) begin
          // Hand over on the same edge when anyone else is waiting.
          pick = arb_pick(req & ~own_mask, ptr_q);
          take = pick[2];
          drop = !pick[2];
        end else begin
          if (hold_q != HOLD_LAST) hold_d = hold_q + 4'd1;
          owner_d = own;
          gnt_d   = own_mask;
          sel_d   = owner_sel(own);
          valid_d = 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase

    if (take) begin
      state_d = BUSY;
      owner_d = pick[1:0];
      ptr_d   = inc3(pick[1:0]);
      hold_d  = '0;
      gnt_d   = onehot(pick[1:0]);
      sel_d   = owner_sel(pick[1:0]);
      valid_d = 1'b1;
    end else if (drop) begin
      state_d = IDLE;
      hold_d  = '0;
      gnt_d   = '0;
      sel_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= SRC0;
      ptr_q   <= SRC0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel1  = sel_q[1];
  assign sel0  = sel_q[0];
  assign valid = valid_q;

  mux3 #(.W(W)) u_mux (
    .sel0 (sel_q[0]),
    .sel1 (sel_q[1]),
    .d0   (din0),
    .d1   (din1),
    .d2   (din2),
    .y    (dout)
  );

endmodule

// File: tb/tb_rr_arb3.sv
// Directed bench for rr_arb3: two instances (burst budget 2 and 4) share stimulus.
module tb_rr_arb3;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [W-1:0] din0, din1, din2;

  logic [2:0]   gnt_a, gnt_b;
  logic         sel0_a, sel1_a, sel0_b, sel1_b;
  logic         valid_a, valid_b;
  logic [W-1:0] dout_a, dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb3 #(.W(W), .MAX_HOLD(2)) dut_a (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2),
    .gnt(gnt_a), .sel0(sel0_a), .sel1(sel1_a), .dout(dout_a), .valid(valid_a)
  );

  rr_arb3 #(.W(W), .MAX_HOLD(4)) dut_b (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2),
    .gnt(gnt_b), .sel0(sel0_b), .sel1(sel1_b), .dout(dout_b), .valid(valid_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks grant plus everything that must follow from it on one instance.
  task automatic chk_port(input string tag, input logic [2:0] g, input logic v,
                          input logic s1, input logic s0, input logic [W-1:0] d,
                          input logic [2:0] exp_g);
    logic [1:0]   exp_sel;
    logic [W-1:0] exp_d;
    case (exp_g)
      3'b010:  begin exp_sel = 2'b01; exp_d = din1; end
      3'b100:  begin exp_sel = 2'b10; exp_d = din2; end
      default: begin exp_sel = 2'b00; exp_d = din0; end
    endcase
    chk({tag, ".gnt"},   32'(g), 32'(exp_g));
    chk({tag, ".valid"}, 32'(v), 32'(exp_g != 3'b000));
    chk({tag, ".sel"},   32'({s1, s0}), 32'(exp_sel));
    chk({tag, ".dout"},  32'(d), 32'(exp_d));
  endtask

  task automatic chk_a(input string tag, input logic [2:0] exp_g);
    chk_port({tag, "/A"}, gnt_a, valid_a, sel1_a, sel0_a, dout_a, exp_g);
  endtask

  task automatic chk_b(input string tag, input logic [2:0] exp_g);
    chk_port({tag, "/B"}, gnt_b, valid_b, sel1_b, sel0_b, dout_b, exp_g);
  endtask

  logic [2:0] rr_seq [0:6];
  logic [2:0] er_a   [0:3];
  logic [2:0] er_b   [0:3];

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    er_a   = '{3'b010, 3'b001, 3'b001, 3'b010};
    er_b   = '{3'b010, 3'b010, 3'b010, 3'b001};

    din0 = 4'h1; din1 = 4'h5; din2 = 4'hA;
    rst  = 1'b1; req = 3'b111;

    // Reset held two cycles with all requests active.
    tick(); tick();
    chk_a("reset", 3'b000);
    chk_b("reset", 3'b000);

    rst = 1'b0;
    tick();
    chk_a("first_grant", 3'b001);
    chk_b("first_grant", 3'b001);

    // Budget 2 under full contention: two cycles per owner, rotating.
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_a($sformatf("rr%0d", i), rr_seq[i]);
    end

    // Sole requester keeps the grant indefinitely.
    rst = 1'b1; tick();
    rst = 1'b0; req = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_b($sformatf("single%0d", i), 3'b100);
      chk_a($sformatf("single%0d", i), 3'b100);
    end

    // Early release: owner 0 drops after one cycle, source 1 takes over at once.
    rst = 1'b1; tick();
    rst = 1'b0; req = 3'b011;
    tick();
    chk_a("early_own0", 3'b001);
    chk_b("early_own0", 3'b001);
    req = 3'b010;
    tick();
    chk_a("early_sw", 3'b010);
    chk_b("early_sw", 3'b010);
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a($sformatf("hold%0d", i), er_a[i]);
      chk_b($sformatf("hold%0d", i), er_b[i]);
    end

    // Reset mid-burst (A owns source 1), then pointer must restart at 0.
    rst = 1'b1;
    tick();
    chk_a("midrst", 3'b000);
    chk_b("midrst", 3'b000);
    rst = 1'b0; req = 3'b110;
    tick();
    chk_a("post_rst", 3'b010);
    chk_b("post_rst", 3'b010);

    // All requests drop: back to idle, selects 00, dout = din0.
    req = 3'b010;
    tick();
    chk_a("drop_pre", 3'b010);
    req = 3'b000;
    tick();
    chk_a("drop", 3'b000);
    chk_b("drop", 3'b000);
    tick();
    chk_a("idle", 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
